knight_rider_scanner: RTL and testbench

//  Parametrised one-hot LED scanner: next generation of the 8-bit ring counter.

---
 rtl/knight_rider_scanner_if.sv | 23 ++
 rtl/knight_rider_scanner.sv | 116 +++++++++++
 tb/tb_knight_rider_scanner.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/knight_rider_scanner_if.sv
// Signal bundle between the LED scanner and whatever controls it.
// Control flows in (en_i, mode_i); registered pattern, direction and strobes flow out.
interface knight_rider_scanner_if #(
   parameter int WIDTH = 8
);
   logic             en_i;
   logic [1:0]       mode_i;
   logic [WIDTH-1:0] pattern_o;
   logic             dir_o;
   logic             step_o;
   logic             wrap_o;
   logic             dbg_state_o;  // 0 = SCAN, 1 = DWELL

   modport master (
      output en_i, mode_i,
      input  pattern_o, dir_o, step_o, wrap_o, dbg_state_o
   );

   modport slave (
      input  en_i, mode_i,
      output pattern_o, dir_o, step_o, wrap_o, dbg_state_o
   );
endinterface

// File: rtl/knight_rider_scanner.sv
// One-hot LED scanner with step prescaler and run-time mode: rotate left/right,
// bounce with end dwell, or hold. Every state change happens on a prescaler tick.
module knight_rider_scanner #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1,
   parameter int DWELL    = 0
) (
   input  logic                  clk_i,
   input  logic                  sys_rst_i,
   knight_rider_scanner_if.slave bus
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [DW-1:0] DWELL_L  = DW'(DWELL);

   typedef enum logic {ST_SCAN = 1'b0, ST_DWELL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic             dir_q, dir_d;
   logic             step_q, wrap_q, wrap_d;
   logic             tick, at_end;
   logic [WIDTH-1:0] rol, ror, fwd, back;

   assign tick = bus.en_i && (cnt_q == CNT_LAST);

   // Plain rotations double as bounce shifts: away from the end they never wrap.
   assign rol    = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
   assign ror    = {pat_q[0], pat_q[WIDTH-1:1]};
   assign fwd    = dir_q ? ror : rol;
   assign back   = dir_q ? rol : ror;
   assign at_end = dir_q ? pat_q[0] : pat_q[WIDTH-1];

   always_comb begin
      pat_d   = pat_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      state_d = state_q;
      dwell_d = dwell_q;
      case (bus.mode_i)
         2'b00: begin
            pat_d   = rol;
            dir_d   = 1'b0;
            wrap_d  = pat_q[WIDTH-1];
            state_d = ST_SCAN;
            dwell_d = '0;
         end
         2'b01: begin
            pat_d   = ror;
            dir_d   = 1'b1;
            wrap_d  = pat_q[0];
            state_d = ST_SCAN;
            dwell_d = '0;
         end
         2'b10: begin
            if (state_q == ST_DWELL) begin
               if (dwell_q < DWELL_L) begin
                  dwell_d = dwell_q + DW'(1);
               end else begin
                  pat_d   = back;
                  dir_d   = ~dir_q;
                  wrap_d  = 1'b1;
                  dwell_d = '0;
                  state_d = ST_SCAN;
               end
            end else if (!at_end) begin
               pat_d = fwd;
            end else if (DWELL == 0) begin
               pat_d  = back;
               dir_d  = ~dir_q;
               wrap_d = 1'b1;
            end else begin
               dwell_d = DW'(1);
               state_d = ST_DWELL;
            end
         end
         default: begin
            state_d = ST_SCAN;
            dwell_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         cnt_q   <= '0;
         pat_q   <= WIDTH'(1);
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         state_q <= ST_SCAN;
         dwell_q <= '0;
      end else begin
         step_q <= tick;
         wrap_q <= tick && wrap_d;
         if (bus.en_i) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
         end
         if (tick) begin
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            dwell_q <= dwell_d;
         end
      end
   end

   assign bus.pattern_o   = pat_q;
   assign bus.dir_o       = dir_q;
   assign bus.step_o      = step_q;
   assign bus.wrap_o      = wrap_q;
   assign bus.dbg_state_o = (state_q == ST_DWELL);
endmodule

// File: tb/tb_knight_rider_scanner.sv
// Bench for knight_rider_scanner: two instances (P=1/D=2 and P=3/D=0) share stimulus
// and are checked every cycle against a position-based reference model.
module tb_knight_rider_scanner;
   localparam int W  = 8;
   localparam int VW = W + 4;
   localparam int PRE [2] = '{1, 3};
   localparam int DWL [2] = '{2, 0};

   logic clk = 1'b0;
   logic sys_rst = 1'b1;

   knight_rider_scanner_if #(.WIDTH(W)) if_a ();
   knight_rider_scanner_if #(.WIDTH(W)) if_b ();

   knight_rider_scanner #(.WIDTH(W), .PRESCALE(1), .DWELL(2)) dut_a (
      .clk_i(clk), .sys_rst_i(sys_rst), .bus(if_a.slave)
   );
   knight_rider_scanner #(.WIDTH(W), .PRESCALE(3), .DWELL(0)) dut_b (
      .clk_i(clk), .sys_rst_i(sys_rst), .bus(if_b.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2*VW-1:0] exp_q[$];

   // Reference model state: LED index, direction, prescaler, dwell.
   int m_pos [2] = '{0, 0};
   int m_dir [2] = '{0, 0};
   int m_cnt [2] = '{0, 0};
   int m_dwc [2] = '{0, 0};
   int m_dwl [2] = '{0, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input int k, input bit rst, input bit en, input logic [1:0] mode,
                             output logic [VW-1:0] v);
      bit tick, wr, at_end;
      int d;
      logic [W-1:0] pat;
      tick = 1'b0;
      wr   = 1'b0;
      if (rst) begin
         m_pos[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_dwc[k] = 0; m_dwl[k] = 0;
      end else if (en) begin
         if (m_cnt[k] == PRE[k] - 1) begin
            m_cnt[k] = 0;
            tick = 1'b1;
         end else begin
            m_cnt[k]++;
         end
      end
      if (tick) begin
         d = (m_dir[k] != 0) ? -1 : 1;
         at_end = (m_dir[k] == 0 && m_pos[k] == W - 1) || (m_dir[k] == 1 && m_pos[k] == 0);
         case (mode)
            2'd0: begin
               m_dir[k] = 0;
               if (m_pos[k] == W - 1) begin m_pos[k] = 0; wr = 1'b1; end
               else m_pos[k]++;
               m_dwl[k] = 0; m_dwc[k] = 0;
            end
            2'd1: begin
               m_dir[k] = 1;
               if (m_pos[k] == 0) begin m_pos[k] = W - 1; wr = 1'b1; end
               else m_pos[k]--;
               m_dwl[k] = 0; m_dwc[k] = 0;
            end
            2'd2: begin
               if ((m_dwl[k] != 0 && m_dwc[k] >= DWL[k]) || (m_dwl[k] == 0 && at_end && DWL[k] == 0)) begin
                  m_dir[k] = 1 - m_dir[k];
                  m_pos[k] = m_pos[k] - d;
                  wr = 1'b1;
                  m_dwc[k] = 0;
                  m_dwl[k] = 0;
               end else if (m_dwl[k] != 0) begin
                  m_dwc[k]++;
               end else if (!at_end) begin
                  m_pos[k] = m_pos[k] + d;
               end else begin
                  m_dwc[k] = 1;
                  m_dwl[k] = 1;
               end
            end
            default: begin
               m_dwl[k] = 0; m_dwc[k] = 0;
            end
         endcase
      end
      pat = W'(1) << m_pos[k];
      v = {pat, m_dir[k][0], tick, wr, m_dwl[k][0]};
   endtask

   task automatic cyc(input bit rst, input bit en, input logic [1:0] mode);
      logic [VW-1:0] va, vb;
      logic [2*VW-1:0] e;
      sys_rst     = rst;
      if_a.en_i   = en;
      if_a.mode_i = mode;
      if_b.en_i   = en;
      if_b.mode_i = mode;
      model_edge(0, rst, en, mode, va);
      model_edge(1, rst, en, mode, vb);
      exp_q.push_back({va, vb});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("a_out", 32'({if_a.pattern_o, if_a.dir_o, if_a.step_o, if_a.wrap_o, if_a.dbg_state_o}),
            32'(e[2*VW-1:VW]));
      check("b_out", 32'({if_b.pattern_o, if_b.dir_o, if_b.step_o, if_b.wrap_o, if_b.dbg_state_o}),
            32'(e[VW-1:0]));
      check("a_onehot", 32'($onehot(if_a.pattern_o)), 32'd1);
      check("b_onehot", 32'($onehot(if_b.pattern_o)), 32'd1);
   endtask

   initial begin
      logic [1:0] rmode;
      if_a.en_i = 1'b0; if_a.mode_i = 2'b00;
      if_b.en_i = 1'b0; if_b.mode_i = 2'b00;

      // Reset, with explicit reset-value checks.
      cyc(1, 1, 2'b00);
      cyc(1, 1, 2'b10);
      check("rst_pat", 32'(if_a.pattern_o), 32'h01);
      check("rst_dir_strobe", 32'({if_a.dir_o, if_a.step_o, if_a.wrap_o}), 32'd0);

      // T1: rotate left on instance a, wrap at 80->01.
      for (int i = 0; i < 7; i++) cyc(0, 1, 2'b00);
      check("t1_msb", 32'({if_a.pattern_o, if_a.step_o, if_a.wrap_o}), 32'({8'h80, 1'b1, 1'b0}));
      cyc(0, 1, 2'b00);
      check("t1_wrap", 32'({if_a.pattern_o, if_a.step_o, if_a.wrap_o}), 32'({8'h01, 1'b1, 1'b1}));
      for (int i = 0; i < 12; i++) cyc(0, 1, 2'b00);

      // T2: rotate right, with an enable gap mid-run.
      for (int i = 0; i < 14; i++) cyc(0, 1, 2'b01);
      for (int i = 0; i < 5; i++) cyc(0, 0, 2'b01);
      for (int i = 0; i < 20; i++) cyc(0, 1, 2'b01);

      // T3/T4: bounce (a has dwell 2, b has none).
      for (int i = 0; i < 60; i++) cyc(0, 1, 2'b10);

      // T5: go to hold while a dwells at the MSB, then rotate left.
      for (int i = 0; i < 60 && !(m_dwl[0] != 0 && m_pos[0] == W - 1); i++) cyc(0, 1, 2'b10);
      check("t5_reach_dwell", 32'(if_a.dbg_state_o), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 2'b11);
      check("t5_hold", 32'({if_a.pattern_o, if_a.step_o, if_a.wrap_o}), 32'({8'h80, 1'b1, 1'b0}));
      cyc(0, 1, 2'b00);
      check("t5_exit", 32'({if_a.pattern_o, if_a.wrap_o, if_a.dbg_state_o}), 32'({8'h01, 1'b1, 1'b0}));
      for (int i = 0; i < 3; i++) cyc(0, 1, 2'b00);

      // T6: reset b mid-scan with its prescaler at 1.
      for (int i = 0; i < 12 && m_cnt[1] != 1; i++) cyc(0, 1, 2'b00);
      check("t6_cnt_phase", 32'(m_cnt[1]), 32'd1);
      cyc(1, 1, 2'b00);
      check("t6_rst", 32'({if_b.pattern_o, if_b.dir_o, if_b.step_o, if_b.wrap_o}), 32'({8'h01, 3'b000}));
      for (int i = 0; i < 6; i++) cyc(0, 1, 2'b00);

      // Random run: sparse mode changes, enable gaps, rare resets.
      rmode = 2'b10;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
         cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, rmode);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
